// File: rtl/ahbl_sram_slave.sv
// ---------------------------------------------------------------------------
// ahbl_sram_slave
//   AHB-Lite responder for the on-chip RAM region.
//   Word-organised SRAM (2^AW x 32 bit) with byte-lane writes. Every accepted
//   transfer gets WAIT_STATES HREADYOUT-low cycles. Misaligned or oversized
//   transfers get a two-cycle ERROR response and leave the memory untouched.
//
// Parameters
//   AW           word-address width, HADDR[AW+1:2] selects the word
//   WAIT_STATES  wait cycles per accepted OK transfer (0..15)
//
// Ports
//   HCLK       in   bus clock, rising edge
//   HRESETn    in   asynchronous reset, active HIGH despite the name
//   HSEL       in   slave select from the decoder
//   HADDR      in   address (bits above AW+1 ignored, the region aliases)
//   HTRANS     in   transfer type, HTRANS[1] marks NONSEQ/SEQ
//   HSIZE      in   0 byte, 1 halfword, 2 word, larger sizes are errors
//   HWRITE     in   1 = write
//   HWDATA     in   write data, valid in the data phase
//   HREADY     in   bus-level ready from the mux
//   HREADYOUT  out  this slave's ready
//   HRESP      out  0 OKAY, 1 ERROR
//   HRDATA     out  read data, zero outside a read's final data-phase cycle
// ---------------------------------------------------------------------------
module ahbl_sram_slave #(
   parameter int AW          = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic        HWRITE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_LAST,
      S_ERR1,
      S_ERR2
   } state_t;

   localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [3:0]      r_cnt;
   logic [3:0]      w_cnt_nxt;
   logic [AW+1:0]   r_addr;
   logic [2:0]      r_size;
   logic            r_write;

   logic            w_open;
   logic            w_accept;
   logic            w_err;
   logic [3:0]      w_be;
   logic [AW-1:0]   w_word;
   logic            w_unused_haddr;

   logic [31:0]     r_mem [2**AW];

   // A new address phase may only be taken while our own data phase is
   // finishing (or absent), i.e. in the states that drive HREADYOUT high.
   assign w_open   = (r_state == S_IDLE) || (r_state == S_LAST) || (r_state == S_ERR2);
   assign w_accept = w_open && HSEL && HTRANS[1] && HREADY;
   assign w_word   = r_addr[AW+1:2];

   // Upper address bits alias onto the region.
   assign w_unused_haddr = ^HADDR[31:AW+2];

   always_comb begin
      case (HSIZE)
         3'd0:    w_err = 1'b0;
         3'd1:    w_err = HADDR[0];
         3'd2:    w_err = |HADDR[1:0];
         default: w_err = 1'b1;
      endcase
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      HREADYOUT   = 1'b1;
      HRESP       = 1'b0;
      case (r_state)
         S_IDLE, S_LAST, S_ERR2: begin
            HRESP = (r_state == S_ERR2);
            if (w_accept) begin
               if (w_err) begin
                  w_state_nxt = S_ERR1;
               end else if (WAIT_STATES > 0) begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = WS_LOAD;
               end else begin
                  w_state_nxt = S_LAST;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            HREADYOUT = 1'b0;
            if (r_cnt == 4'd0) begin
               w_state_nxt = S_LAST;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_ERR1: begin
            HREADYOUT   = 1'b0;
            HRESP       = 1'b1;
            w_state_nxt = S_ERR2;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge HCLK or posedge HRESETn) begin
      if (HRESETn) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= '0;
         r_size  <= 3'd0;
         r_write <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_addr  <= HADDR[AW+1:0];
            r_size  <= HSIZE;
            r_write <= HWRITE;
         end
      end
   end

   // Lane enables; HWDATA lanes are written in place, never shifted.
   always_comb begin
      case (r_size)
         3'd0:    w_be = 4'b0001 << r_addr[1:0];
         3'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
         default: w_be = 4'b1111;
      endcase
   end

   // NOTE: the memory array has no reset; clearing it would need a reset
   // fan-out to every word and the contents are undefined after power-up.
   // The commit happens on the edge that ends LAST, which is also the edge
   // that may accept a following read, so read-after-write needs no bypass.
   always_ff @(posedge HCLK) begin
      if (!HRESETn && (r_state == S_LAST) && r_write) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               r_mem[w_word][8*b +: 8] <= HWDATA[8*b +: 8];
            end
         end
      end
   end

   assign HRDATA = ((r_state == S_LAST) && !r_write) ? r_mem[w_word] : 32'h0;

endmodule
